demultiplexer1to2_stream: RTL

DEMULTIPLEXER1TO2_STREAM -- requirements
Module: demultiplexer1to2_stream

---
 rtl/demultiplexer_package.sv | 11 +
 rtl/demultiplexer_channel_slot.sv | 74 +++++++
 rtl/demultiplexer1to2_stream.sv | 58 +++++
 3 files changed

// File: rtl/demultiplexer_package.sv
// rtl/demultiplexer_package.sv - shared slot state encoding and counter width
package demultiplexer_package;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/demultiplexer_channel_slot.sv
// rtl/demultiplexer_channel_slot.sv - one-word holding register with EMPTY/FULL control
// Optional saturating transfer counter under DEMULTIPLEXER1TO2_COUNT_EN.
module demultiplexer_channel_slot
  import demultiplexer_package::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  empty
`ifdef DEMULTIPLEXER1TO2_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] count
`endif
);

  slot_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  out_fire;

  assign out_valid = (state_q == FULL);
  assign empty     = (state_q == EMPTY);
  assign out_data  = data_q;
  assign out_fire  = out_valid & out_ready;

  // A load wins over a drain, so a coincident consume and load keeps the slot full.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if (out_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

`ifdef DEMULTIPLEXER1TO2_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (out_fire && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: rtl/demultiplexer1to2_stream.sv
// rtl/demultiplexer1to2_stream.sv - 1-to-2 valid/ready stream demultiplexer
// Per-channel transfer counters and the transfer_count port exist only under DEMULTIPLEXER1TO2_COUNT_EN.
module demultiplexer1to2_stream
  import demultiplexer_package::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [DATA_WIDTH-1:0]   input_signal,
  input  logic                    selection,
  output logic [1:0]              output_valid,
  input  logic [1:0]              output_ready,
  output logic [2*DATA_WIDTH-1:0] output_signal
`ifdef DEMULTIPLEXER1TO2_COUNT_EN
  ,
  output logic [2*COUNT_WIDTH-1:0] transfer_count
`endif
);

  logic [1:0] slot_empty;
  logic [1:0] load;
  logic       accept;

  // Ready only looks at the selected slot, so a stalled slot never blocks the other.
  always_comb begin
    input_ready = 1'b0;
    if (!reset) begin
      input_ready = slot_empty[selection] | output_ready[selection];
    end
  end

  assign accept  = input_valid & input_ready;
  assign load[0] = accept & ~selection;
  assign load[1] = accept & selection;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    demultiplexer_channel_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .load     (load[i]),
      .load_data(input_signal),
      .out_ready(output_ready[i]),
      .out_valid(output_valid[i]),
      .out_data (output_signal[i*DATA_WIDTH +: DATA_WIDTH]),
      .empty    (slot_empty[i])
`ifdef DEMULTIPLEXER1TO2_COUNT_EN
      ,
      .count    (transfer_count[i*COUNT_WIDTH +: COUNT_WIDTH])
`endif
    );
  end

endmodule
